seq_state_monitor: RTL and testbench



---
 rtl/seq_state_monitor.sv | 121 ++++++++++++
 tb/tb_seq_state_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_state_monitor.sv
// seq_state_monitor
// Observational checker for the 4-bit T-flip-flop state counter. It watches the
// {A,B,C,D} state vector and checks that each accepted sample equals the
// previous one plus STEP (mod 16). It reports lock status, transition errors,
// target hits and saturating match/miss counts. It drives nothing back into
// the counter.
// Optional build macro: SEQ_STATE_MON_CAPTURE_EN. When it is defined, the
// expected and actual values of the first mismatch since reset/clear are held
// on err_exp/err_act. Otherwise both outputs read as zero.

module seq_state_monitor #(
    parameter int         STEP   = 1,
    parameter logic [3:0] TARGET = 4'hF,
    parameter int         LOCK_N = 3,
    parameter int         CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       st_in,
    input  logic             st_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic             err_pulse,
    output logic             hit,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [3:0]       err_exp,
    output logic [3:0]       err_act
);

    localparam logic [3:0] STEP4 = 4'(STEP);
    localparam logic [3:0] LOCK4 = 4'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t     state;
    logic [3:0] prev;
    logic [3:0] consec;
    logic [3:0] expected;
    logic       is_match;
    logic       mismatch;

    // Next value the counter should present. The 4-bit add makes the 15->0 wrap free.
    assign expected = prev + STEP4;
    assign is_match = (st_in == expected);
    // A comparison happens only on an accepted sample after the first one.
    // Reset and clear take priority and drop the sample.
    assign mismatch = reset && !clear && st_valid && (state != IDLE) && !is_match;

    // Tracking FSM, with counters and status flags updated together on each accepted sample.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state     <= IDLE;
            prev      <= 4'h0;
            consec    <= 4'h0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            hit       <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            err_pulse <= 1'b0;
            hit       <= 1'b0;
            if (st_valid) begin
                hit  <= (st_in == TARGET);
                prev <= st_in;
                if (state == IDLE) begin
                    consec <= 4'h0;
                    state  <= ACQUIRE;
                    locked <= 1'b0;
                end else if (is_match) begin
                    if (match_cnt != {CNT_W{1'b1}}) begin
                        match_cnt <= match_cnt + CNT_W'(1);
                    end
                    if (consec != LOCK4) begin
                        consec <= consec + 4'd1;
                    end
                    if ((state == ACQUIRE) && (consec + 4'd1 == LOCK4)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end else begin
                    if (miss_cnt != {CNT_W{1'b1}}) begin
                        miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                    err       <= 1'b1;
                    err_pulse <= 1'b1;
                    consec    <= 4'h0;
                    state     <= ACQUIRE;
                    locked    <= 1'b0;
                end
            end
        end
    end

`ifdef SEQ_STATE_MON_CAPTURE_EN
    // Freeze the first mismatch after reset/clear. The err flag blocks later
    // mismatches from overwriting it.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            err_exp <= 4'h0;
            err_act <= 4'h0;
        end else if (mismatch && !err) begin
            err_exp <= expected;
            err_act <= st_in;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = mismatch;
    assign err_exp = 4'h0;
    assign err_act = 4'h0;
`endif

endmodule

// File: tb/tb_seq_state_monitor.sv
// tb_seq_state_monitor
// Directed and light random stimulus for seq_state_monitor. Two instances share
// the same inputs: one has the default 8-bit counters and the other has 2-bit
// counters, so that counter saturation is visible. A reference model computes
// the expected outputs when each step is driven. The result is pushed to a
// scoreboard queue, then popped and compared after the clock edge.

module tb_seq_state_monitor;

    localparam int         STEP   = 1;
    localparam logic [3:0] TARGET = 4'hF;
    localparam int         LOCK_N = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] st_in;
    logic       st_valid;
    logic       clear;

    logic       a_locked, a_err, a_err_pulse, a_hit;
    logic [7:0] a_match, a_miss;
    logic [3:0] a_exp, a_act;
    logic       b_locked, b_err, b_err_pulse, b_hit;
    logic [1:0] b_match, b_miss;
    logic [3:0] b_exp, b_act;

    seq_state_monitor #(.STEP(STEP), .TARGET(TARGET), .LOCK_N(LOCK_N), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .st_in(st_in), .st_valid(st_valid), .clear(clear),
        .locked(a_locked), .err(a_err), .err_pulse(a_err_pulse), .hit(a_hit),
        .match_cnt(a_match), .miss_cnt(a_miss), .err_exp(a_exp), .err_act(a_act)
    );

    seq_state_monitor #(.STEP(STEP), .TARGET(TARGET), .LOCK_N(LOCK_N), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .st_in(st_in), .st_valid(st_valid), .clear(clear),
        .locked(b_locked), .err(b_err), .err_pulse(b_err_pulse), .hit(b_hit),
        .match_cnt(b_match), .miss_cnt(b_miss), .err_exp(b_exp), .err_act(b_act)
    );

    // Free-running clock with a 10-unit period.
    always #5 clock = ~clock;

    typedef struct {
        logic       locked;
        logic       err;
        logic       err_pulse;
        logic       hit;
        int         match_raw;
        int         miss_raw;
        logic [3:0] exp_v;
        logic [3:0] act_v;
    } exp_t;

    exp_t sb_q[$];

    int pass_count  = 0;
    int fail_count  = 0;
    int check_count = 0;

    // Reference model state. The counts are kept unsaturated and clipped per counter width.
    int         m_state;
    logic [3:0] m_prev;
    int         m_consec;
    int         m_match, m_miss;
    logic       m_err, m_pulse, m_hit;
    logic [3:0] m_exp, m_act;

    function automatic int sat(input int raw, input int width);
        int top;
        top = (1 << width) - 1;
        return (raw > top) ? top : raw;
    endfunction

    task automatic checkField(input string tag, input logic [31:0] act, input logic [31:0] req);
        check_count++;
        assert (act === req) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, req);
        end
    endtask

    task automatic modelStep(input logic rst_n, input logic clr, input logic vld, input logic [3:0] st);
        logic [3:0] want;
        if (!rst_n || clr) begin
            m_state = 0; m_prev = 4'h0; m_consec = 0; m_match = 0; m_miss = 0;
            m_err = 1'b0; m_pulse = 1'b0; m_hit = 1'b0; m_exp = 4'h0; m_act = 4'h0;
        end else begin
            m_pulse = 1'b0;
            m_hit   = 1'b0;
            if (vld) begin
                m_hit = (st == TARGET);
                if (m_state == 0) begin
                    m_state  = 1;
                    m_consec = 0;
                end else begin
                    want = 4'((m_prev + STEP) % 16);
                    if (st == want) begin
                        m_match++;
                        if (m_consec < LOCK_N) m_consec++;
                        if (m_state == 1 && m_consec == LOCK_N) m_state = 2;
                    end else begin
                        m_miss++;
                        if (!m_err) begin
                            m_exp = want;
                            m_act = st;
                        end
                        m_err    = 1'b1;
                        m_pulse  = 1'b1;
                        m_consec = 0;
                        m_state  = 1;
                    end
                end
                m_prev = st;
            end
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [3:0] want_exp, want_act;
        if (sb_q.size() == 0) begin
            checkField("scoreboard_empty", 32'(1), 32'(0));
            return;
        end
        e = sb_q.pop_front();
`ifdef SEQ_STATE_MON_CAPTURE_EN
        want_exp = e.exp_v;
        want_act = e.act_v;
`else
        want_exp = 4'h0;
        want_act = 4'h0;
`endif
        checkField("a_locked",    32'(a_locked),    32'(e.locked));
        checkField("a_err",       32'(a_err),       32'(e.err));
        checkField("a_err_pulse", 32'(a_err_pulse), 32'(e.err_pulse));
        checkField("a_hit",       32'(a_hit),       32'(e.hit));
        checkField("a_match_cnt", 32'(a_match),     32'(sat(e.match_raw, 8)));
        checkField("a_miss_cnt",  32'(a_miss),      32'(sat(e.miss_raw, 8)));
        checkField("a_err_exp",   32'(a_exp),       32'(want_exp));
        checkField("a_err_act",   32'(a_act),       32'(want_act));
        checkField("b_locked",    32'(b_locked),    32'(e.locked));
        checkField("b_err",       32'(b_err),       32'(e.err));
        checkField("b_match_cnt", 32'(b_match),     32'(sat(e.match_raw, 2)));
        checkField("b_miss_cnt",  32'(b_miss),      32'(sat(e.miss_raw, 2)));
    endtask

    // Drive one clock's worth of inputs away from the rising edge, then check just after it.
    task automatic applyStimulus(input logic rst_n, input logic clr, input logic vld, input logic [3:0] st);
        exp_t e;
        @(negedge clock);
        reset    = rst_n;
        clear    = clr;
        st_valid = vld;
        st_in    = st;
        modelStep(rst_n, clr, vld, st);
        e.locked    = (m_state == 2);
        e.err       = m_err;
        e.err_pulse = m_pulse;
        e.hit       = m_hit;
        e.match_raw = m_match;
        e.miss_raw  = m_miss;
        e.exp_v     = m_exp;
        e.act_v     = m_act;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic sample(input logic [3:0] st);
        applyStimulus(1'b1, 1'b0, 1'b1, st);
    endtask

    task automatic gap();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    // Stop the run if it stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence, followed by a short random stretch.
    initial begin
        logic [3:0] nxt;
        reset = 1'b0; clear = 1'b0; st_valid = 1'b0; st_in = 4'h0;

        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h5);
        checkField("tp_reset_match", 32'(a_match), 32'(0));

        // Startup run 0..4: the lock comes after sample 3.
        sample(4'h0); sample(4'h1); sample(4'h2);
        checkField("tp_not_locked_yet", 32'(a_locked), 32'(0));
        sample(4'h3);
        checkField("tp_locked_after_3", 32'(a_locked), 32'(1));
        sample(4'h4);
        checkField("tp_match_4", 32'(a_match), 32'(4));
        checkField("tp_miss_0", 32'(a_miss), 32'(0));

        // Wrap from 0xF to 0x0, with the hit at the target.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
        sample(4'hE);
        sample(4'hF);
        checkField("tp_hit_at_F", 32'(a_hit), 32'(1));
        sample(4'h0);
        checkField("tp_hit_one_cycle", 32'(a_hit), 32'(0));
        sample(4'h1);
        checkField("tp_wrap_match_3", 32'(a_match), 32'(3));
        checkField("tp_wrap_no_err", 32'(a_err), 32'(0));

        // Skip from 6 to 9 while locked, then lock again.
        sample(4'h2); sample(4'h3); sample(4'h4); sample(4'h5); sample(4'h6);
        sample(4'h9);
        checkField("tp_skip_pulse", 32'(a_err_pulse), 32'(1));
        checkField("tp_skip_unlock", 32'(a_locked), 32'(0));
        checkField("tp_skip_miss", 32'(a_miss), 32'(1));
`ifdef SEQ_STATE_MON_CAPTURE_EN
        checkField("tp_capture_exp", 32'(a_exp), 32'(7));
        checkField("tp_capture_act", 32'(a_act), 32'(9));
`endif
        sample(4'hA);
        checkField("tp_pulse_drops", 32'(a_err_pulse), 32'(0));
        sample(4'hB); sample(4'hC);
        checkField("tp_relock", 32'(a_locked), 32'(1));

        // Gaps between valid samples.
        sample(4'hD); gap(); gap(); sample(4'hE); gap(); sample(4'hF); gap();

        // Repeated mismatches saturate the narrow counter.
        sample(4'h5); sample(4'h5); sample(4'h5); sample(4'h5); sample(4'h5);
        checkField("tp_b_miss_sat", 32'(b_miss), 32'(3));
        checkField("tp_a_miss_6", 32'(a_miss), 32'(6));

        // Clear beats a sample in the same cycle.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h1);
        checkField("tp_clear_err", 32'(a_err), 32'(0));
        sample(4'h5);
        checkField("tp_post_clear_no_cmp", 32'(a_miss), 32'(0));
        sample(4'h6); sample(4'h7); sample(4'h8);
        checkField("tp_locked_again", 32'(a_locked), 32'(1));

        // Reset while locked, with a sample present that must be dropped.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'hA);
        checkField("tp_reset_unlock", 32'(a_locked), 32'(0));
        sample(4'h3);
        checkField("tp_reset_no_cmp", 32'(a_miss), 32'(0));
        sample(4'h4);
        checkField("tp_reset_match_1", 32'(a_match), 32'(1));

        // Mostly in-step samples, with occasional jumps, gaps and clears.
        for (int i = 0; i < 60; i++) begin
            nxt = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_prev + 4'(STEP));
            if ($urandom_range(0, 24) == 0)
                applyStimulus(1'b1, 1'b1, 1'b1, nxt);
            else
                applyStimulus(1'b1, 1'b0, ($urandom_range(0, 3) != 0), nxt);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
